// File: rtl/reg_file.sv
// Architectural register file with RoB rename tags, commit/flush handling and a retired-instruction counter.
// Optional same-cycle commit forwarding to the read ports is enabled by defining REG_COMMIT_BYPASS_EN.
module reg_file #(
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned NREG     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic [4:0]          issue_rd,
  input  logic [ROB_ID_W-1:0] issue_rob_id,
  input  logic [4:0]          commit_rd,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [31:0]         commit_value,
  input  logic                clear,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  output logic [31:0]         val1,
  output logic [31:0]         val2,
  output logic                busy1,
  output logic                busy2,
  output logic [ROB_ID_W-1:0] tag1,
  output logic [ROB_ID_W-1:0] tag2,
  output logic [31:0]         instret
);

  logic [31:0]         value_q [NREG];
  logic [31:0]         value_d [NREG];
  logic [ROB_ID_W-1:0] tag_q   [NREG];
  logic [ROB_ID_W-1:0] tag_d   [NREG];
  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_d;
  logic [31:0]         instret_q;
  logic [31:0]         instret_d;

  logic commit_v;
  logic issue_v;

  assign commit_v = (commit_rd != '0) && (32'(commit_rd) < NREG);
  assign issue_v  = (issue_rd  != '0) && (32'(issue_rd)  < NREG);

  // Commit is applied before issue so a same-cycle rename of the same rd keeps it busy.
  always_comb begin
    value_d   = value_q;
    tag_d     = tag_q;
    busy_d    = busy_q;
    instret_d = instret_q;
    if (rdy) begin
      if (commit_v) begin
        value_d[commit_rd] = commit_value;
        instret_d          = instret_q + 32'd1;
        if (busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id)) begin
          busy_d[commit_rd] = 1'b0;
          tag_d[commit_rd]  = '0;
        end
      end
      if (clear) begin
        busy_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
          tag_d[i] = '0;
        end
      end else if (issue_v) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_rob_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q    <= '0;
      instret_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
      busy_q    <= busy_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

  always_comb begin
    val1  = '0;
    busy1 = 1'b0;
    tag1  = '0;
    if ((rs1 != '0) && (32'(rs1) < NREG)) begin
      val1  = value_q[rs1];
      busy1 = busy_q[rs1];
      tag1  = tag_q[rs1];
`ifdef REG_COMMIT_BYPASS_EN
      if (rdy && (commit_rd == rs1) && busy_q[rs1] && (tag_q[rs1] == commit_rob_id)) begin
        val1  = commit_value;
        busy1 = 1'b0;
        tag1  = '0;
      end
`endif
    end
  end

  always_comb begin
    val2  = '0;
    busy2 = 1'b0;
    tag2  = '0;
    if ((rs2 != '0) && (32'(rs2) < NREG)) begin
      val2  = value_q[rs2];
      busy2 = busy_q[rs2];
      tag2  = tag_q[rs2];
`ifdef REG_COMMIT_BYPASS_EN
      if (rdy && (commit_rd == rs2) && busy_q[rs2] && (tag_q[rs2] == commit_rob_id)) begin
        val2  = commit_value;
        busy2 = 1'b0;
        tag2  = '0;
      end
`endif
    end
  end

endmodule

// File: doc/reg_file.md
# reg_file

- Architectural register file with rename tags for the out-of-order core.
- Sits between the RoB and the decoder/RS/LSB:
  - consumes the RoB's issue and commit channels and its flush;
  - serves combinational source-operand reads to the decoder.
- Per register: holds the committed 32-bit value, a busy bit and the RoB id of the youngest in-flight writer.
- Also keeps a retired-instruction counter.

## Interface

Parameters:
- ROB_ID_W, default 4: RoB index width; must equal the RoB's id width.
- NREG, default 32: register count; x0 hardwired.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset (clears state immediately on assertion, independent of clk)
- rdy  in  1  global enable; low = hold all state, ignore write inputs
- issue_rd  in  5  destination being renamed this cycle; 0 = no issue
- issue_rob_id  in  ROB_ID_W  RoB slot allocated to issue_rd
- commit_rd  in  5  destination retiring this cycle; 0 = no commit
- commit_rob_id  in  ROB_ID_W  RoB slot retiring
- commit_value  in  32  retiring result
- clear  in  1  misprediction flush from RoB
- rs1, rs2  in  5  source register indices from decoder
- val1, val2  out  32  committed (or bypassed) value of rs1/rs2
- busy1, busy2  out  1  operand still pending in RoB
- tag1, tag2  out  ROB_ID_W  RoB id producing the operand; 0 when not busy
- instret  out  32  count of committed register-writing instructions

## Operation

- State per register r: value[r] (32b), busy[r], tag[r] (ROB_ID_W).
- Register x0:
  - value/busy/tag constant 0;
  - writes and renames to x0 are ignored.
- Issue (rdy=1, clear=0, issue_rd≠0): busy[issue_rd]←1, tag[issue_rd]←issue_rob_id.
- Commit (rdy=1, commit_rd≠0):
  - value[commit_rd]←commit_value always.
  - If busy[commit_rd] and tag[commit_rd]==commit_rob_id, then busy←0 and tag←0.
  - On tag mismatch (a younger writer exists), busy and tag are unchanged.
  - instret←instret+1, wrapping at 2^32.
- Issue and commit to the same rd in one cycle:
  - value takes commit_value;
  - busy stays 1 and tag takes issue_rob_id (issue wins).
- Clear (rdy=1, clear=1):
  - A commit in the same cycle is applied first: value written, instret increments.
  - Then every busy←0 and tag←0.
  - Issue is ignored.
- rdy=0: no state changes; read ports remain live.
- Read (combinational, per port p with index rsp):
  - rsp==0 → val=0, busy=0, tag=0.
  - Otherwise → val=value[rsp], busy=busy[rsp], tag=tag[rsp], subject to the bypass below.
  - Reads reflect state before this cycle's issue, so an instruction never sees its own rename.

## Timing

- Reset: asynchronous on rst falling. All value/busy/tag←0, instret←0. While rst=0, outputs are val*=0, busy*=0, tag*=0, instret=0.
- Issue/commit/clear take effect at the posedge they are sampled. Without bypass, results are visible on read ports the next cycle.
- Read ports have zero latency from rs1/rs2 and from stored state.
- rst asserted mid-operation discards pending renames. The RoB is reset by the same event, so no stale commit is accepted afterwards.

## Configuration

REG_COMMIT_BYPASS_EN:
- Defined: same-cycle commit forwarding to both read ports. When rdy=1, commit_rd≠0, rsp==commit_rd, busy[rsp]=1 and tag[rsp]==commit_rob_id, the port outputs val=commit_value, busy=0, tag=0.
- Not defined: ports show only stored state. A matching commit becomes visible one cycle later, and the consumer picks it up from the RoB/RS broadcast instead.

## Test plan

- Reset, then read rs1=5, rs2=0 → val=0, busy=0, tag=0; instret=0. Assert rst low mid-stream after renaming x5 → busy1 drops to 0 immediately, without waiting for clk.
- Issue x5→rob 3; next cycle read rs1=5 → busy1=1, tag1=3. Commit x5/rob 3/0xDEADBEEF; next cycle → val1=0xDEADBEEF, busy1=0, instret=1.
- Issue x7→rob 2, then x7→rob 4; commit x7/rob 2/0x11 → value=0x11, busy1=1, tag1=4. Commit rob 4/0x22 → busy1=0, val1=0x22.
- Same cycle: commit x9/rob 1/0x55 and issue x9→rob 6 → next cycle val=0x55, busy=1, tag=6. Issue x0→rob 5 → x0 reads 0/not busy.
- Rename x3→rob 1 and x4→rob 2, then pulse clear → both not busy, values unchanged. An issue during the clear cycle is dropped. Toggle rdy=0 with an issue and a commit present → no change.
- With REG_COMMIT_BYPASS_EN: x6 busy tag 5; commit x6/rob 5/0xCAFE with rs2=6 → same cycle val2=0xCAFE, busy2=0. Without the macro → same cycle busy2=1, tag2=5; next cycle val2=0xCAFE.
